// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: MEM-stage load/store initiator for a word-wide,
// single-port, write-first synchronous RAM with registered dout.
// Sub-word stores are read-modify-write because the RAM has no byte enables.
// Lane selection and merge logic assume XLEN == 32 (four byte lanes).
module dmem_lsu_ctrl #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [2:0]               req_funct3,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [XLEN-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]          mem_din,
  input  logic [XLEN-1:0]          mem_dout
);

  localparam int LANES = XLEN / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_RD   = 3'd1,
    LOAD_DATA = 3'd2,
    SW_WR     = 3'd3,
    RMW_RD    = 3'd4,
    RMW_WR    = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Only the bits that reach the RAM (word index + lane offset) are kept;
  // higher address bits wrap modulo RAM size.
  logic [ADDRESS_WIDTH+1:0] lat_addr;
  logic [XLEN-1:0]          lat_wdata;
  logic [2:0]               lat_f3;
  logic                     lat_we;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDRESS_WIDTH+2];

  logic accept, f3_bad, misal, req_err;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] rmw_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_addr  = lat_addr[ADDRESS_WIDTH+1:2];

  // Decode illegal width codes and misalignment from the live request.
  always_comb begin
    f3_bad = 1'b0;
    misal  = 1'b0;
    if (req_we) f3_bad = (req_funct3 > 3'd2);
    else        f3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    case (req_funct3[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = (req_addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
    req_err = f3_bad || misal;
  end

  // Load lane extraction and sign/zero extension from the registered RAM word.
  always_comb begin
    ld_byte = mem_dout[7:0];
    case (lat_addr[1:0])
      2'd1:    ld_byte = mem_dout[15:8];
      2'd2:    ld_byte = mem_dout[23:16];
      2'd3:    ld_byte = mem_dout[31:24];
      default: ld_byte = mem_dout[7:0];
    endcase
    ld_half = lat_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (lat_f3)
      3'd0:    ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'd5:    ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_dout;
    endcase
  end

  // Per-lane RMW merge: replace the addressed byte/half lane with store data.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic       hit;
    logic [7:0] wbyte;
    assign hit   = (lat_f3[1:0] == 2'd0) ? (lat_addr[1:0] == LANE) : (lat_addr[1] == LANE[1]);
    assign wbyte = ((lat_f3[1:0] == 2'd1) && LANE[0]) ? lat_wdata[15:8] : lat_wdata[7:0];
    assign rmw_data[8*i +: 8] = hit ? wbyte : mem_dout[8*i +: 8];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latches, captured on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      lat_we    <= 1'b0;
    end else if (accept) begin
      lat_addr  <= req_addr[ADDRESS_WIDTH+1:0];
      lat_wdata <= req_wdata;
      lat_f3    <= req_funct3;
      lat_we    <= req_we;
    end
  end

  // Next-state and RAM drive; RAM writes only happen in the two write states.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_din   = '0;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_we)                 state_nxt = LOAD_RD;
          else if (req_funct3 == 3'd2) state_nxt = SW_WR;
          else                         state_nxt = RMW_RD;
        end
      end
      LOAD_RD:   state_nxt = LOAD_DATA;
      LOAD_DATA: state_nxt = IDLE;
      SW_WR: begin
        mem_we    = lat_we;
        mem_din   = lat_wdata;
        state_nxt = IDLE;
      end
      RMW_RD:    state_nxt = RMW_WR;
      RMW_WR: begin
        mem_we    = lat_we;
        mem_din   = rmw_data;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Response register: one-cycle valid pulse, data/err held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept && req_err) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else begin
        case (state)
          LOAD_DATA: begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext;
          end
          SW_WR, RMW_WR: begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
